result_drain: RTL
=================

Name: result_drain

Overview:
- Output stage directly downstream of the storage unit's output cache.
- Captures one completed result row (MATSIZE words of BITWIDTH bits) into a two-entry ping-pong row buffer.
- Serialises each row word-by-word onto a valid/ready stream toward the host/DMA interface.
- Tags row and matrix boundaries, and flags any row lost to back-pressure.

Parameters:
- BITWIDTH, 32, width of one signed result element.
- MATSIZE, 16, elements per row and rows per matrix; must be ≥ 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of buffer, counters and overflow flag.
- row_valid  in  1  one-cycle pulse: row_data holds a complete result row.
- row_data  in  MATSIZE×BITWIDTH (packed [MATSIZE-1:0][BITWIDTH-1:0], signed)  result row; element 0 is sent first.
- row_ready  out  1  buffer has a free slot.
- m_valid  out  1  stream word valid.
- m_data  out  BITWIDTH (signed)  stream word.
- m_last  out  1  marks the last word of a row.
- m_eom  out  1  marks the last word of the last row of a matrix (asserted together with m_last).
- m_ready  in  1  downstream accepts the word.
- overflow  out  1  sticky: a row arrived while the buffer was full.
- rows_sent  out  $clog2(MATSIZE)+1  rows fully drained in the current matrix.

Behaviour:
- Reset (rst_n=0, asynchronous): every output and internal register goes to 0. This includes wr_ptr, rd_ptr, count, word_idx, row_idx, both buffer entries and overflow. row_ready therefore reads 1 immediately after reset is released.
- Reset mid-stream: any row in flight is discarded. No partial handshake completes after reset. After release, the block behaves as freshly reset.
- clear (synchronous, takes priority over every other event in the same cycle): produces the same state as reset. The buffer contents may be left as they are.
- row_ready = (count < 2). It is a function of registered state only; m_ready does not reach it combinationally.
- Capture: if row_valid && row_ready, then row_data → buf[wr_ptr], wr_ptr toggles, count +1.
- If row_valid && !row_ready: the row is dropped, overflow is set to 1, and it stays 1 until reset or clear. The pop in that same cycle still proceeds normally. A slot freed by a pop in the same cycle does not admit the row.
- m_valid = (count > 0). It is registered-state driven, with no combinational path from m_ready.
- m_data = buf[rd_ptr][word_idx], driven combinationally from registers. Latency: a row captured at edge N presents word 0 in the cycle after edge N.
- Handshake: a word transfers when m_valid && m_ready. On transfer, word_idx +1.
- If word_idx = MATSIZE-1 on a transfer, then on the same edge:
  - word_idx wraps to 0;
  - rd_ptr toggles;
  - count −1;
  - row_idx +1, wrapping to 0 after MATSIZE-1;
  - rows_sent +1, reset to 0 on the wrap.
- Simultaneous capture and final-word pop: count is unchanged, both pointers toggle, and the stream continues back-to-back with no bubble.
- m_valid && !m_ready: m_data, m_last and m_eom hold stable until the transfer.
- m_last = m_valid && (word_idx == MATSIZE-1).
- m_eom = m_last && (row_idx == MATSIZE-1).
- Drain state machine (derived from count/word_idx, no separate enum needed):
  - EMPTY (count=0).
  - STREAM (count≥1, row in progress).
  - FULL (count=2, row_ready=0).
  - Transitions occur only on capture/pop as above.
- Sustained throughput: 1 word/clk while m_ready=1, so one row every MATSIZE cycles. Upstream may deliver at most one row per MATSIZE cycles without overflow.

Decomposition:
- Shared package (matmul_pkg):
  - BITWIDTH and MATSIZE defaults;
  - typedef elem_t = logic signed [BITWIDTH-1:0];
  - typedef row_t = elem_t [MATSIZE-1:0];
  - localparams for IDX_W and ROW_CNT_W.
- One natural sub-module: row_pingpong_buf. It holds the 2-entry storage plus wr_ptr/rd_ptr/count, with push/pop/full/empty ports.
- The serialiser (word_idx, row_idx, flags) stays in result_drain.

Test Plan:
- Reset release, then a single row with elements 0x10..0x1F and m_ready=1:
  - row_ready=1 before the row;
  - m_valid rises the cycle after capture;
  - 16 consecutive words 0x10..0x1F;
  - m_last only on 0x1F;
  - rows_sent=1.
- Back-pressure: m_ready toggled 1,0,1,0 over row 0xA0..0xAF → m_data and m_last hold stable while m_ready=0; all 16 words arrive in order with no duplicates.
- Full and overflow, with m_ready=0:
  - push rows R0, R1, then R2 → row_ready=0 after R1, overflow=1 after R2;
  - releasing m_ready streams R0 then R1 only (32 words), and overflow stays 1;
  - clear sets overflow back to 0.
- Back-to-back: a new row is pushed on the exact cycle the final word of the current row transfers (count=1) → no bubble; word 0 of the next row appears on the following cycle.
- Matrix boundary: push 16 rows (values row*16+col) with m_ready=1 → m_eom asserts exactly once, on word 255 (value 0xFF); rows_sent wraps to 0; row 17 streams with m_eom=0.
- Asynchronous reset asserted mid-row at word 7 (between clock edges) → m_valid=0 and overflow=0 immediately; row_ready=1 after release; a subsequent row streams from word 0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply datapath.
//   BITWIDTH / MATSIZE : default element width and matrix dimension
//   IDX_W              : width of a word-within-row or row-within-matrix index
//   ROW_CNT_W          : width of a count that can reach MATSIZE
//   elem_t / row_t     : one signed result element / one full result row
//   drain_state_t      : observable occupancy state of the result drain
package matmul_pkg;

   localparam int BITWIDTH  = 32;
   localparam int MATSIZE   = 16;
   localparam int IDX_W     = $clog2(MATSIZE);
   localparam int ROW_CNT_W = $clog2(MATSIZE) + 1;

   typedef logic signed [BITWIDTH-1:0] elem_t;
   typedef elem_t [MATSIZE-1:0]        row_t;

   typedef enum logic [1:0] {
      DRAIN_EMPTY  = 2'd0,
      DRAIN_STREAM = 2'd1,
      DRAIN_FULL   = 2'd2
   } drain_state_t;

endpackage

// File: rtl/row_pingpong_buf.sv
// Two-entry ping-pong row store.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush of pointers and occupancy (entries kept)
//   push, din  : write din into the entry at wr_ptr (caller guarantees !full)
//   pop        : retire the entry at rd_ptr (caller guarantees !empty)
//   dout       : entry at rd_ptr
//   full/empty : occupancy flags, count : occupancy 0..2
module row_pingpong_buf #(
   parameter int W = 512
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   logic [W-1:0] entry0;
   logic [W-1:0] entry1;
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry0 <= '0;
         entry1 <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else if (clear) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            if (wr_ptr) entry1 <= din;
            else        entry0 <= din;
            wr_ptr <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         // Push and pop together leave the occupancy unchanged.
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign dout  = rd_ptr ? entry1 : entry0;
   assign full  = (cnt == 2'd2);
   assign empty = (cnt == 2'd0);
   assign count = cnt;

endmodule

// File: rtl/result_drain.sv
// Result drain: captures completed result rows into a ping-pong buffer and
// serialises them word-by-word onto a valid/ready stream.
//   clk, rst_n, clear      : clock, async active-low reset, sync flush
//   row_valid, row_data    : one-cycle row delivery (element 0 sent first)
//   row_ready              : a buffer slot is free
//   m_valid/m_data/m_ready : output stream
//   m_last, m_eom          : last word of a row / of the last row of a matrix
//   overflow               : sticky, a row arrived while the buffer was full
//   rows_sent              : rows fully drained in the current matrix
//   drain_state            : EMPTY / STREAM / FULL occupancy view
//
// Handshake: a word moves on a clock edge where m_valid && m_ready. m_valid,
// m_data, m_last and m_eom depend on registered state only, so they stay
// stable while m_ready is low; row_ready likewise never depends on m_ready.
module result_drain
   import matmul_pkg::*;
#(
   parameter int BITWIDTH = matmul_pkg::BITWIDTH,
   parameter int MATSIZE  = matmul_pkg::MATSIZE
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     clear,
   input  logic                                     row_valid,
   input  logic signed [MATSIZE-1:0][BITWIDTH-1:0]  row_data,
   output logic                                     row_ready,
   output logic                                     m_valid,
   output logic signed [BITWIDTH-1:0]               m_data,
   output logic                                     m_last,
   output logic                                     m_eom,
   input  logic                                     m_ready,
   output logic                                     overflow,
   output logic [$clog2(MATSIZE):0]                 rows_sent,
   output drain_state_t                             drain_state
);

   localparam int IW = $clog2(MATSIZE);
   localparam int RW = IW + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(MATSIZE - 1);

   logic                               buf_full;
   logic                               buf_empty;
   logic [1:0]                         buf_count;
   logic [MATSIZE*BITWIDTH-1:0]        buf_dout;
   logic [MATSIZE-1:0][BITWIDTH-1:0]   cur_row;
   logic                               push;
   logic                               xfer;
   logic                               row_done;

   logic [IW-1:0] word_idx;
   logic [IW-1:0] row_idx;
   logic [RW-1:0] sent_q;

   // A row arriving while full is dropped even if a pop frees a slot on the
   // same edge: row_ready is taken from the registered occupancy.
   assign push     = row_valid && row_ready;
   assign xfer     = m_valid && m_ready;
   assign row_done = xfer && (word_idx == LAST_IDX);

   row_pingpong_buf #(
      .W (MATSIZE*BITWIDTH)
   ) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (push),
      .pop   (row_done),
      .din   (row_data),
      .dout  (buf_dout),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count)
   );

   assign cur_row   = buf_dout;
   assign row_ready = !buf_full;
   assign m_valid   = !buf_empty;
   assign m_data    = cur_row[word_idx];
   assign m_last    = m_valid && (word_idx == LAST_IDX);
   assign m_eom     = m_last && (row_idx == LAST_IDX);
   assign rows_sent = sent_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_idx <= '0;
         row_idx  <= '0;
         sent_q   <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         word_idx <= '0;
         row_idx  <= '0;
         sent_q   <= '0;
         overflow <= 1'b0;
      end else begin
         if (row_valid && !row_ready) overflow <= 1'b1;
         if (xfer) begin
            if (word_idx == LAST_IDX) begin
               word_idx <= '0;
               // rows_sent restarts with each new matrix.
               if (row_idx == LAST_IDX) begin
                  row_idx <= '0;
                  sent_q  <= '0;
               end else begin
                  row_idx <= row_idx + 1'b1;
                  sent_q  <= sent_q + 1'b1;
               end
            end else begin
               word_idx <= word_idx + 1'b1;
            end
         end
      end
   end

   always_comb begin
      drain_state = DRAIN_EMPTY;
      if (buf_count == 2'd2)      drain_state = DRAIN_FULL;
      else if (buf_count != 2'd0) drain_state = DRAIN_STREAM;
   end

endmodule
